// File: rtl/btn_conditioner_if.sv
// Button conditioner bus.
//   btn        raw asynchronous push buttons (1 = pressed)
//   repeat_en  auto-repeat enable, synchronous, shared by all lanes
//   btn_level  debounced button level
//   btn_pulse  registered single-cycle press / repeat strobes
// master: the button/control side; slave: the conditioner.
interface btn_conditioner_if #(
  parameter int NUM_LANES = 4
);
  logic [NUM_LANES-1:0] btn;
  logic                 repeat_en;
  logic [NUM_LANES-1:0] btn_level;
  logic [NUM_LANES-1:0] btn_pulse;

  modport master (output btn, repeat_en, input btn_level, btn_pulse);
  modport slave  (input btn, repeat_en, output btn_level, btn_pulse);
endinterface

// File: rtl/btn_conditioner.sv
// Four-channel push-button conditioner: 2-FF synchroniser, debouncer and a
// press/auto-repeat pulse generator per channel. Channels are independent.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    btn_conditioner_if.slave (btn, repeat_en in; btn_level, btn_pulse out)

// One conditioning lane.
module btn_cond_lane #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  input  logic repeat_en_i,
  output logic level_o,
  output logic pulse_o
);
  localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {RELEASED, DELAY, REPEAT} state_e;

  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  state_e        state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          pulse_q, pulse_d;
  logic          rise, fall;

  // Debounce: a disagreement run of DEBOUNCE_CYCLES edges flips the level;
  // any agreeing cycle restarts the run.
  always_comb begin
    level_d = level_q;
    dcnt_d  = '0;
    if (s2_q != level_q) begin
      if (dcnt_q == D_LAST) level_d = s2_q;
      else                  dcnt_d  = dcnt_q + 1'b1;
    end
  end

  // Edges are taken from the next level so the press pulse lands on the
  // same clock edge as the level change.
  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    pulse_d = 1'b0;
    if (fall) begin
      // release wins over a repeat due on the same edge
      state_d = RELEASED;
      rcnt_d  = '0;
    end else begin
      case (state_q)
        RELEASED: begin
          rcnt_d = '0;
          if (rise) begin
            pulse_d = 1'b1;
            state_d = DELAY;
          end
        end
        DELAY: begin
          if (!repeat_en_i) rcnt_d = '0;
          else if (rcnt_q == RD_LAST) begin
            pulse_d = 1'b1;
            rcnt_d  = '0;
            state_d = REPEAT;
          end else rcnt_d = rcnt_q + 1'b1;
        end
        REPEAT: begin
          if (!repeat_en_i) begin
            // re-enabling restarts the full initial delay
            rcnt_d  = '0;
            state_d = DELAY;
          end else if (rcnt_q == RR_LAST) begin
            pulse_d = 1'b1;
            rcnt_d  = '0;
          end else rcnt_d = rcnt_q + 1'b1;
        end
        default: begin
          rcnt_d  = '0;
          state_d = RELEASED;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      level_q <= 1'b0;
      dcnt_q  <= '0;
      state_q <= RELEASED;
      rcnt_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      s1_q    <= btn_i;
      s2_q    <= s1_q;
      level_q <= level_d;
      dcnt_q  <= dcnt_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign level_o = level_q;
  assign pulse_o = pulse_q;
endmodule

module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int NUM_LANES       = 4
) (
  input logic              clk,
  input logic              rst_n,
  btn_conditioner_if.slave bus
);
  logic [NUM_LANES-1:0] level_w, pulse_w;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    btn_cond_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_RATE     (REPEAT_RATE)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_i       (bus.btn[g]),
      .repeat_en_i (bus.repeat_en),
      .level_o     (level_w[g]),
      .pulse_o     (pulse_w[g])
    );
  end

  assign bus.btn_level = level_w;
  assign bus.btn_pulse = pulse_w;
endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner with D=4, REPEAT_DELAY=10, REPEAT_RATE=3.
// A per-channel behavioural model (disagreement run length and count of
// consecutive enabled held cycles) is compared on every falling edge, plus
// hand-computed literal checks for each scenario.
module tb_btn_conditioner;
  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  btn_conditioner_if bus ();

  btn_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_RATE     (RR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int e0;

  // model state
  logic ms1[4], ms2[4], mlvl[4], mpul[4];
  int   mrun[4], menr[4];
  logic [3:0] seen;
  int pq0[$];
  int pq2[$];

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_i(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      ms1[c] = 0; ms2[c] = 0; mlvl[c] = 0; mpul[c] = 0;
      mrun[c] = 0; menr[c] = 0;
    end
  endtask

  // Advance the model across the coming rising edge with the inputs it samples.
  task automatic model_step();
    for (int c = 0; c < 4; c++) begin
      logic s2o, prev;
      s2o  = ms2[c];
      prev = mlvl[c];
      ms2[c] = ms1[c];
      ms1[c] = bus.btn[c];
      if (s2o != mlvl[c]) begin
        mrun[c]++;
        if (mrun[c] == D) begin
          mlvl[c] = s2o;
          mrun[c] = 0;
        end
      end else mrun[c] = 0;
      if (!prev && mlvl[c]) begin
        mpul[c] = 1'b1;
        menr[c] = 0;
      end else if (!mlvl[c]) begin
        mpul[c] = 1'b0;
      end else begin
        menr[c] = bus.repeat_en ? menr[c] + 1 : 0;
        mpul[c] = (menr[c] >= RD) && (((menr[c] - RD) % RR) == 0);
      end
    end
  endtask

  task automatic compare();
    logic [3:0] el, ep;
    for (int c = 0; c < 4; c++) begin
      el[c] = mlvl[c];
      ep[c] = mpul[c];
    end
    chk("model_level", bus.btn_level, el);
    chk("model_pulse", bus.btn_pulse, ep);
    seen = seen | bus.btn_pulse;
    if (bus.btn_pulse[0]) pq0.push_back(cyc);
    if (bus.btn_pulse[2]) pq2.push_back(cyc);
  endtask

  // Each step: check/advance model at the falling edge, then land 2 time
  // units after the next rising edge, where inputs change and literals are read.
  task automatic wait_edges(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (!rst_n) model_reset();
      compare();
      if (rst_n) model_step();
      @(posedge clk);
      cyc++;
      #2;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.btn = 4'b0000;
    bus.repeat_en = 1'b0;
    seen = 4'b0000;
    model_reset();
    wait_edges(3);
    chk("reset_level", bus.btn_level, 4'b0000);
    chk("reset_pulse", bus.btn_pulse, 4'b0000);
    rst_n = 1'b1;
    wait_edges(2);

    // 1: clean press and release, no repeat
    bus.btn = 4'b0001;
    wait_edges(5);
    chk("s1_level_before", bus.btn_level, 4'b0000);
    wait_edges(1);
    chk("s1_level_rise", bus.btn_level, 4'b0001);
    chk("s1_press_pulse", bus.btn_pulse, 4'b0001);
    wait_edges(1);
    chk("s1_pulse_drop", bus.btn_pulse, 4'b0000);
    wait_edges(13);
    bus.btn = 4'b0000;
    wait_edges(5);
    chk("s1_level_held", bus.btn_level, 4'b0001);
    wait_edges(1);
    chk("s1_level_fall", bus.btn_level, 4'b0000);
    chk("s1_no_rel_pulse", bus.btn_pulse, 4'b0000);
    wait_edges(3);

    // 2: bounce rejection on channel 1
    seen = 4'b0000;
    bus.btn = 4'b0010; wait_edges(3);
    bus.btn = 4'b0000; wait_edges(1);
    bus.btn = 4'b0010; wait_edges(2);
    bus.btn = 4'b0000; wait_edges(10);
    chk("s2_level", bus.btn_level, 4'b0000);
    chk("s2_no_pulse", seen & 4'b0010, 4'b0000);

    // 3: auto-repeat, release collides with a due repeat
    bus.repeat_en = 1'b1;
    pq2.delete();
    bus.btn = 4'b0100;
    e0 = cyc + 1;
    wait_edges(40);
    bus.btn = 4'b0000;
    wait_edges(6);
    chk("s3_rel_level", bus.btn_level, 4'b0000);
    chk("s3_rel_no_pulse", bus.btn_pulse, 4'b0000);
    chk_i("s3_count", pq2.size(), 11);
    if (pq2.size() == 11) begin
      chk_i("s3_press", pq2[0], e0 + 5);
      chk_i("s3_first_rep", pq2[1], e0 + 15);
      chk_i("s3_second_rep", pq2[2], e0 + 18);
      chk_i("s3_last_rep", pq2[10], e0 + 42);
    end
    bus.repeat_en = 1'b0;
    wait_edges(2);

    // 4: simultaneous then staggered presses
    bus.btn = 4'b1111;
    wait_edges(6);
    chk("s4_all_pulse", bus.btn_pulse, 4'b1111);
    chk("s4_all_level", bus.btn_level, 4'b1111);
    wait_edges(1);
    chk("s4_all_drop", bus.btn_pulse, 4'b0000);
    bus.btn = 4'b0000;
    wait_edges(8);
    bus.btn = 4'b0001; wait_edges(1);
    bus.btn = 4'b0011; wait_edges(1);
    bus.btn = 4'b0111; wait_edges(1);
    bus.btn = 4'b1111;
    wait_edges(3);
    chk("s4_stag0", bus.btn_pulse, 4'b0001);
    wait_edges(1);
    chk("s4_stag1", bus.btn_pulse, 4'b0010);
    wait_edges(1);
    chk("s4_stag2", bus.btn_pulse, 4'b0100);
    wait_edges(1);
    chk("s4_stag3", bus.btn_pulse, 4'b1000);
    wait_edges(1);
    chk("s4_stag_end", bus.btn_pulse, 4'b0000);
    bus.btn = 4'b0000;
    wait_edges(8);

    // 5: asynchronous reset while repeating
    bus.repeat_en = 1'b1;
    bus.btn = 4'b1000;
    wait_edges(20);
    chk("s5_held_level", bus.btn_level, 4'b1000);
    #1 rst_n = 1'b0;
    #1;
    chk("s5_rst_level", bus.btn_level, 4'b0000);
    chk("s5_rst_pulse", bus.btn_pulse, 4'b0000);
    wait_edges(2);
    rst_n = 1'b1;
    wait_edges(5);
    chk("s5_pre_pulse", bus.btn_pulse, 4'b0000);
    wait_edges(1);
    chk("s5_new_press", bus.btn_pulse, 4'b1000);
    bus.btn = 4'b0000;
    bus.repeat_en = 1'b0;
    wait_edges(8);

    // 6: repeat disabled mid-hold, then re-enabled
    bus.repeat_en = 1'b1;
    pq0.delete();
    bus.btn = 4'b0001;
    e0 = cyc + 1;
    wait_edges(20);
    bus.repeat_en = 1'b0;
    wait_edges(8);
    bus.repeat_en = 1'b1;
    wait_edges(11);
    bus.btn = 4'b0000;
    chk_i("s6_count", pq0.size(), 4);
    if (pq0.size() >= 4) begin
      chk_i("s6_press", pq0[0], e0 + 5);
      chk_i("s6_rep2", pq0[2], e0 + 18);
      chk_i("s6_reenable", pq0[3], e0 + 37);
    end
    wait_edges(8);
    bus.repeat_en = 1'b0;
    wait_edges(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
